// File: rtl/audio_min_max_interval.sv
// Per-interval signed min/max scanner over a flattened frame of 32-bit audio samples, one sample per clock.
// Optional feature: define AUDIO_MIN_MAX_RANGE_EN to add the out_range port (max - min per slot, 33-bit).
module audio_min_max_interval #(
    parameter int N             = 100,
    parameter int NUM_INTERVALS = N / 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [15:0]                   interval_len,
    input  logic [N*32-1:0]               raw_audio,
    output logic                          done,
    output logic [NUM_INTERVALS*32-1:0]   out_max,
    output logic [NUM_INTERVALS*32-1:0]   out_min
`ifdef AUDIO_MIN_MAX_RANGE_EN
    ,
    output logic [NUM_INTERVALS*33-1:0]   out_range
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, state_next;

    logic [15:0]        len_q;
    logic [15:0]        pos;
    logic [31:0]        m_q;
    logic [31:0]        idx;
    logic [31:0]        slot;
    logic signed [31:0] run_max;
    logic signed [31:0] run_min;

    logic               accept;
    logic [15:0]        l_eff;
    logic [31:0]        span;
    logic [31:0]        m_start;
    logic signed [31:0] sample;
    logic               first;
    logic               last;
    logic signed [31:0] new_max;
    logic signed [31:0] new_min;

    assign accept  = start && (state == IDLE || state == DONE);
    assign l_eff   = (interval_len == 16'd0) ? 16'd1 : interval_len;
    assign span    = 32'(NUM_INTERVALS) * {16'd0, l_eff};
    assign m_start = (span > 32'(N)) ? 32'(N) : span;

    // The running extremes restart from the first sample of every interval; ties keep the stored value.
    assign sample  = $signed(raw_audio[32*idx +: 32]);
    assign first   = (pos == 16'd0);
    assign last    = (pos == len_q - 16'd1) || (idx == m_q - 32'd1);
    assign new_max = (first || sample > run_max) ? sample : run_max;
    assign new_min = (first || sample < run_min) ? sample : run_min;

`ifdef AUDIO_MIN_MAX_RANGE_EN
    logic [32:0] diff;
    assign diff = {new_max[31], new_max} - {new_min[31], new_min};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (idx >= m_q) state_next = DONE;
            DONE:    if (start) state_next = SCAN;
            default: state_next = IDLE;
        endcase
    end

    // done rises one edge after the final fold, when the scan sees the index has reached M.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q     <= '0;
            m_q       <= '0;
            idx       <= '0;
            pos       <= '0;
            slot      <= '0;
            run_max   <= '0;
            run_min   <= '0;
            done      <= 1'b0;
            out_max   <= '0;
            out_min   <= '0;
`ifdef AUDIO_MIN_MAX_RANGE_EN
            out_range <= '0;
`endif
        end else if (accept) begin
            len_q     <= l_eff;
            m_q       <= m_start;
            idx       <= '0;
            pos       <= '0;
            slot      <= '0;
            run_max   <= '0;
            run_min   <= '0;
            done      <= 1'b0;
            out_max   <= '0;
            out_min   <= '0;
`ifdef AUDIO_MIN_MAX_RANGE_EN
            out_range <= '0;
`endif
        end else if (state == SCAN) begin
            if (idx < m_q) begin
                idx     <= idx + 32'd1;
                run_max <= new_max;
                run_min <= new_min;
                if (last) begin
                    out_max[32*slot +: 32]   <= new_max;
                    out_min[32*slot +: 32]   <= new_min;
`ifdef AUDIO_MIN_MAX_RANGE_EN
                    out_range[33*slot +: 33] <= diff;
`endif
                    slot <= slot + 32'd1;
                    pos  <= '0;
                end else begin
                    pos <= pos + 16'd1;
                end
            end else begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_min_max_interval.sv
// Self-checking bench for audio_min_max_interval: directed frames plus randomized frames against a behavioural model.
// Honours AUDIO_MIN_MAX_RANGE_EN to also check out_range.
module tb_audio_min_max_interval;

    localparam int N  = 100;
    localparam int NI = N / 10;

    logic              clk;
    logic              reset;
    logic              start;
    logic [15:0]       interval_len;
    logic [N*32-1:0]   raw_audio;
    logic              done;
    logic [NI*32-1:0]  out_max;
    logic [NI*32-1:0]  out_min;
`ifdef AUDIO_MIN_MAX_RANGE_EN
    logic [NI*33-1:0]  out_range;
`endif

    int checks;
    int failures;
    int frame[N];
    int exp_max[NI];
    int exp_min[NI];
    int exp_m;

    audio_min_max_interval #(.N(N), .NUM_INTERVALS(NI)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .interval_len (interval_len),
        .raw_audio    (raw_audio),
        .done         (done),
        .out_max      (out_max),
        .out_min      (out_min)
`ifdef AUDIO_MIN_MAX_RANGE_EN
        ,
        .out_range    (out_range)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Interval k spans samples k*L .. min(k*L+L, M)-1 with M = min(N, NI*L); empty slots stay zero.
    function automatic void compute_model(input int len);
        int le, lo, hi;
        le    = (len == 0) ? 1 : len;
        exp_m = (NI * le < N) ? NI * le : N;
        for (int k = 0; k < NI; k++) begin
            exp_max[k] = 0;
            exp_min[k] = 0;
            lo = k * le;
            if (lo < exp_m) begin
                hi = (lo + le < exp_m) ? lo + le : exp_m;
                exp_max[k] = frame[lo];
                exp_min[k] = frame[lo];
                for (int i = lo + 1; i < hi; i++) begin
                    if (frame[i] > exp_max[k]) exp_max[k] = frame[i];
                    if (frame[i] < exp_min[k]) exp_min[k] = frame[i];
                end
            end
        end
    endfunction

    function automatic void make_drift_frame();
        int dmax[NI] = '{7, 4, 1, -2, -5, -8, -11, -14, -16, -19};
        int dmin[NI] = '{0, -2, -5, -8, -13, -15, -18, -21, -24, -27};
        int w[10]    = '{4, 8, 2, 0, 3, 5, 6, 1, 7, 2};
        int k, j;
        for (int i = 0; i < N; i++) begin
            k = i / 10;
            j = i % 10;
            frame[i] = (dmin[k] + ((dmax[k] - dmin[k]) * w[j]) / 8) * 65536;
        end
    endfunction

    task automatic load_frame();
        for (int i = 0; i < N; i++) raw_audio[32*i +: 32] = frame[i];
    endtask

    task automatic applyStimulus(input int len);
        @(negedge clk);
        interval_len = 16'(len);
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int elapsed, input int exp_edge);
        int edges;
        edges = elapsed;
        if (elapsed == 0) begin
            checkOutput({tag, "_done_low"}, done, 0);
            checkOutput({tag, "_max_clear"}, |out_max, 0);
            checkOutput({tag, "_min_clear"}, |out_min, 0);
        end
        while (!done && edges < exp_edge + 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, "_done_edge"}, edges, exp_edge);
        repeat (3) @(posedge clk);
        #1 checkOutput({tag, "_done_hold"}, done, 1);
    endtask

    task automatic checkResults(input string tag);
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s_max%0d", tag, k), $signed(out_max[32*k +: 32]), exp_max[k]);
            checkOutput($sformatf("%s_min%0d", tag, k), $signed(out_min[32*k +: 32]), exp_min[k]);
`ifdef AUDIO_MIN_MAX_RANGE_EN
            checkOutput($sformatf("%s_rng%0d", tag, k), {31'd0, out_range[33*k +: 33]},
                        longint'(exp_max[k]) - longint'(exp_min[k]));
`endif
        end
    endtask

    task automatic run_case(input string tag, input int len);
        compute_model(len);
        applyStimulus(len);
        waitDone(tag, 0, exp_m + 1);
        checkResults(tag);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        start        = 1'b0;
        interval_len = '0;
        raw_audio    = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_done", done, 0);
        checkOutput("reset_max", |out_max, 0);
        checkOutput("reset_min", |out_min, 0);
        @(negedge clk) reset = 1'b1;

        make_drift_frame();
        load_frame();
        run_case("l10", 10);
        checkOutput("l10_s0_max", $signed(out_max[0 +: 32]), 458752);
        checkOutput("l10_s0_min", $signed(out_min[0 +: 32]), 0);
        checkOutput("l10_s1_max", $signed(out_max[32 +: 32]), 262144);
        checkOutput("l10_s1_min", $signed(out_min[32 +: 32]), -131072);
        checkOutput("l10_s4_max", $signed(out_max[128 +: 32]), -327680);
        checkOutput("l10_s4_min", $signed(out_min[128 +: 32]), -851968);
        checkOutput("l10_s9_max", $signed(out_max[288 +: 32]), -1245184);
        checkOutput("l10_s9_min", $signed(out_min[288 +: 32]), -1769472);

        run_case("l30", 30);
        checkOutput("l30_s3_max", $signed(out_max[96 +: 32]), -1245184);
        checkOutput("l30_s3_min", $signed(out_min[96 +: 32]), -1769472);
        checkOutput("l30_hi_zero", |out_max[NI*32-1:128], 0);

        run_case("l5", 5);
        checkOutput("l5_s0_max", $signed(out_max[0 +: 32]), 458752);
        checkOutput("l5_s0_min", $signed(out_min[0 +: 32]), 0);

        for (int i = 0; i < N; i++) frame[i] = -7;
        load_frame();
        run_case("l0", 0);
        checkOutput("l0_s7_max", $signed(out_max[224 +: 32]), -7);

        // Abort mid-scan with reset (start held high too), then a fresh run must match cleanly.
        make_drift_frame();
        load_frame();
        compute_model(10);
        applyStimulus(10);
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_done", done, 0);
        checkOutput("abort_max", |out_max, 0);
        checkOutput("abort_min", |out_min, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        run_case("fresh", 10);

        // A start pulse during SCAN with a different length must be ignored.
        compute_model(10);
        applyStimulus(10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        interval_len = 16'd3;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("ignore", 5, exp_m + 1);
        checkResults("ignore");

        run_case("restart", 10);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++)
                frame[i] = (it % 2 == 1) ? int'($urandom_range(0, 6)) - 3 : int'($urandom);
            load_frame();
            run_case($sformatf("rnd%0d", it), int'($urandom_range(0, 40)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_min_max_interval.md
AUDIO_MIN_MAX_INTERVAL -- requirements
Module: audio_min_max_interval

Interface
REQ-001 Parameter N, default 100: number of 32-bit signed samples in the input frame.
REQ-002 Parameter NUM_INTERVALS, default N/10: number of interval result slots.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  begin a computation; sampled only in IDLE or DONE.
REQ-006 interval_len  input  16  samples per interval (unsigned); captured when start is accepted.
REQ-007 raw_audio  input  N*32  flattened two's-complement samples; sample i occupies bits [32*i+31:32*i]; must be held stable from start until done.
REQ-008 done  output  1  high when all results are valid.
REQ-009 out_max  output  NUM_INTERVALS*32  per-interval signed maximum; slot k occupies bits [32*k+31:32*k].
REQ-010 out_min  output  NUM_INTERVALS*32  per-interval signed minimum; same packing as out_max.

Function
REQ-011 The FSM SHALL have three states: IDLE, SCAN and DONE.
- IDLE->SCAN, or DONE->SCAN, on start=1.
- SCAN->DONE after the last sample is folded.
- DONE holds until start or reset.
REQ-012 On start acceptance, the block SHALL:
- latch L = interval_len, with L=0 treated as 1;
- clear out_max, out_min and done to 0;
- set the sample index to 0.
REQ-013 The number of processed samples SHALL be M = min(N, NUM_INTERVALS*L); samples at index >= M are ignored.
REQ-014 SCAN SHALL fold exactly one sample per clock, in index order 0..M-1.
REQ-015 Interval k SHALL cover samples k*L .. min(k*L+L, M)-1.
REQ-016 The running max and min SHALL be initialised from the first sample of each interval.
REQ-017 All comparisons SHALL be signed 32-bit; no saturation or widening is applied.
REQ-018 When the last sample of interval k is folded, out_max[k] and out_min[k] SHALL be written in that same edge, including a partial final interval.
REQ-019 Slots k with k*L >= M SHALL remain 0.
REQ-020 done SHALL rise on clock edge M+1, counting the start-accepting edge as edge 0; with defaults this is 101 cycles.
REQ-021 done SHALL stay high, and the outputs stable, until the next accepted start or reset.
REQ-022 start during SCAN SHALL be ignored.
REQ-023 start in DONE SHALL restart the computation: done falls on the accepting edge.
REQ-024 Results for equal samples: max equals min equals that value; ties do not change the stored value.

Reset
REQ-025 On reset=0 at a rising clk edge, the block SHALL enter IDLE and set to 0: done, out_max, out_min, the sample index, the interval counter, the running max/min and the latched L.
REQ-026 Reset during SCAN SHALL abort the computation; no partial results remain.
REQ-027 reset SHALL take priority over start on the same edge.

Configuration
REQ-028 With AUDIO_MIN_MAX_RANGE_EN defined, the block SHALL add output port out_range (NUM_INTERVALS*33 bits).
- Slot k = out_max[k] - out_min[k] as a 33-bit unsigned value.
- Written on the same edge as out_max[k]; 0 on reset and on start.
REQ-029 Without AUDIO_MIN_MAX_RANGE_EN, the out_range port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Default parameters, L=10, the standard 100-sample descending-drift frame, start pulse -> done on edge 101; the bench checks:
- slot 0: max 458752, min 0;
- slot 1: max 262144, min -131072;
- slot 4: max -327680, min -851968;
- slot 9: max -1245184, min -1769472.
REQ-031 Same frame, L=30 -> M=100, slots 0..3 written:
- slot 3 = samples 90..99, max -1245184, min -1769472;
- slots 4..9 = 0;
- done on edge 101.
REQ-032 Same frame, L=5 -> M=50, only samples 0..49 used:
- slot 0 = samples 0..4, max 458752, min 0;
- done on edge 51.
REQ-033 L=0 with all samples equal to -7 -> treated as L=1, M=10; every slot max=min=-7.
REQ-034 reset=0 asserted at SCAN cycle 20, then a new start -> all outputs 0 and done=0 during reset; the fresh run matches REQ-030 exactly.
REQ-035 start pulsed again at SCAN cycle 5 -> ignored; start pulsed in DONE -> done drops on the accepting edge, outputs clear, and the run repeats.
